// File: rtl/sram_like_resp_pkg.sv
// sram_like_pkg: shared size encodings, LFSR constants and response-queue entry type
package sram_like_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Galois form of x^16+x^14+x^13+x^11+1 for a right-shifting register
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        is_write;
        logic [31:0] data;
        logic [7:0]  stamp;
    } entry_t;

endpackage

// File: rtl/sram_like_resp_if.sv
// sram_like_resp_if: SRAM-like request/response bus between an initiator and the responder
interface sram_like_resp_if;
    import sram_like_pkg::*;

    logic        req;
    logic        wr;
    size_e       size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);

endinterface

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo: DEPTH-entry in-order queue of accepted requests awaiting their response
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Status flags, guarded push/pop and next pointer/count values; pointers wrap as DEPTH is a power of 2
    always_comb begin
        full    = cnt_q == (PW+1)'(DEPTH);
        empty   = cnt_q == '0;
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wp_d    = wp_q + PW'(do_push);
        rp_d    = rp_q + PW'(do_pop);
        cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        dout    = mem_q[rp_q];
        count   = cnt_q;
    end

    // Pointer and occupancy state; a reset empties the queue and discards anything outstanding
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: only slots between the pointers are ever read meaningfully
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/sram_like_resp.sv
// sram_like_resp: SRAM-like responder, in-order data_ok at least LATENCY cycles after accept;
// define SRAM_LIKE_RESP_RANDOM_DELAY_EN to add LFSR-driven jitter on addr_ok and data_ok
module sram_like_resp
    import sram_like_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int AW      = 12
) (
    input  logic             clk,
    input  logic             resetn,
    sram_like_resp_if.slave  bus
);

    logic [7:0]              cnt_q, cnt_d;
    logic [31:0]             mem_q [2**AW];
    logic [AW-1:0]           idx;
    logic                    full, empty, push, pop, acc_gate, rsp_gate;
    logic [$clog2(DEPTH):0]  count;
    entry_t                  din, head;
    logic                    unused_ok;

`ifdef SRAM_LIKE_RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Next LFSR state; bit 0 throttles acceptance, bit 1 throttles responses
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end

    // LFSR restarts from the seed on every reset so jitter is repeatable
    always_ff @(posedge clk) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign acc_gate = lfsr_q[0];
    assign rsp_gate = lfsr_q[1];
`else
    assign acc_gate = 1'b1;
    assign rsp_gate = 1'b1;
`endif

    // Handshake, response selection and the entry captured at accept (reads sample memory before any later write)
    always_comb begin
        cnt_d       = cnt_q + 8'd1;
        idx         = bus.addr[AW+1:2];
        bus.addr_ok = resetn & ~full & acc_gate;
        push        = bus.req & resetn & ~full & acc_gate;
        bus.data_ok = resetn & ~empty & rsp_gate & ((cnt_q - head.stamp) >= 8'(LATENCY));
        pop         = bus.data_ok;
        bus.rdata   = (bus.data_ok & ~head.is_write) ? head.data : 32'h0;
        din         = '{is_write: bus.wr, data: bus.wr ? 32'h0 : mem_q[idx], stamp: cnt_q};
    end

    // Free-running cycle counter; ages use modulo-256 differences against the stamp
    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    // Byte-lane writes land at the accept edge; contents survive reset
    always_ff @(posedge clk) begin
        if (push & bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    sram_like_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (din),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // Size and the address bits outside the word index are informational only
    assign unused_ok = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0], count};

endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 SHALL have parameter DEPTH, 4, maximum outstanding accepted requests (power of 2, 2..16).
REQ-002 SHALL have parameter LATENCY, 2, minimum cycles from accept to data_ok (1..255).
REQ-003 SHALL have parameter AW, 12, word-address width of internal memory (2^AW 32-bit words).
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  1  request valid from initiator.
REQ-007 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port size  input  2  access size (0 byte, 1 half, 2 word); informational only.
REQ-009 SHALL have port wstrb  input  4  write byte-lane enables.
REQ-010 SHALL have port addr  input  32  byte address.
REQ-011 SHALL have port wdata  input  32  write data.
REQ-012 SHALL have port addr_ok  output  1  request accepted this cycle when req high.
REQ-013 SHALL have port data_ok  output  1  one-cycle response pulse, one per accepted request.
REQ-014 SHALL have port rdata  output  32  read data, valid only with data_ok.

Function
REQ-015 SHALL accept a request in a cycle where req & addr_ok; addr_ok combinational = ~full (no same-cycle bypass on retire).
REQ-016 SHALL index memory by addr[AW+1:2]; addr[1:0] and addr[31:AW+2] ignored (aliasing).
REQ-017 SHALL perform writes at the accept edge, updating only byte lanes with wstrb set.
REQ-018 SHALL sample read data at the accept edge into the queue entry (read-after-write in accept order).
REQ-019 SHALL hold accepted requests in a DEPTH-entry FIFO: {is_write, data, stamp}; wrapping pointers, count 0..DEPTH.
REQ-020 SHALL keep an 8-bit free-running cycle counter; stamp = counter at accept; modulo-256 subtraction.
REQ-021 SHALL assert data_ok for head entry when (counter - stamp) >= LATENCY; pop on that cycle.
REQ-022 SHALL respond strictly in accept order, at most one data_ok per cycle; no backpressure on data_ok.
REQ-023 SHALL drive rdata = head data for reads, 32'h0 for writes, 32'h0 when data_ok low.
REQ-024 SHALL allow simultaneous push and pop when not full; count unchanged.
REQ-025 SHALL, when empty, produce earliest data_ok LATENCY cycles after accept (back-to-back accepts retire on consecutive cycles).

Reset
REQ-026 SHALL, while resetn low, drive addr_ok=0, data_ok=0, rdata=0; pointers, count, counter cleared.
REQ-027 SHALL discard all outstanding entries on reset mid-operation; no data_ok for them after release.
REQ-028 SHALL NOT reset memory contents.

Configuration
REQ-029 SHALL, with SRAM_LIKE_RESP_RANDOM_DELAY_EN defined, run a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) gating addr_ok with lfsr[0] and data_ok eligibility with lfsr[1].
REQ-030 SHALL, without the macro, contain no LFSR and behave deterministically per REQ-015/021.
REQ-031 SHALL preserve ordering and one-response-per-accept in both configurations.

Structure
REQ-032 SHALL place size encodings (BYTE/HALF/WORD) and LFSR seed/taps constants in shared package sram_like_pkg.
REQ-033 SHALL implement the response queue as sub-module sram_like_resp_fifo (push/pop/full/empty/count).

Verification
REQ-034 SHALL cover: write addr 32'h100 wdata 32'hDEADBEEF wstrb 4'hF, then read 32'h100 -> data_ok with rdata 32'hDEADBEEF, read data_ok exactly 2 cycles after its accept (LATENCY=2).
REQ-035 SHALL cover: wstrb 4'b0010 wdata 32'h0000AB00 over 32'h11223344 -> later read returns 32'h1122AB44.
REQ-036 SHALL cover: req held high 6 cycles, DEPTH=4, no retire yet -> addr_ok high 4 cycles then low until first data_ok pops.
REQ-037 SHALL cover: reset asserted with 3 outstanding -> no data_ok after release; next read of written address returns pre-reset memory value.
REQ-038 SHALL cover: addr 32'h4 and 32'h4004 (AW=12) -> alias same word; addr[1:0]=2'b11 read returns aligned word.
REQ-039 SHALL cover with SRAM_LIKE_RESP_RANDOM_DELAY_EN: 1000 random reads/writes vs scoreboard -> in-order, every accept answered exactly once.
